// File: rtl/dyn_sync_fifo.sv
// dyn_sync_fifo: single-clock FIFO on an inferred simple-dual-port RAM with a
// registered read port, occupancy counter and run-time almost-full/empty flags.
module dyn_sync_fifo #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] pop_data,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] L_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] L_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE:0]   r_wr_ptr;
  logic [ADDR_SIZE:0]   r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;
  logic [DATA_SIZE-1:0] r_pop_data;
  logic                 r_overflow;
  logic                 r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == L_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = pop & ~w_empty;
  // A push while full is still taken when a pop frees a slot in the same cycle.
  assign w_push_ok = push & (~w_full | w_pop_ok);

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[ADDR_SIZE-1:0]] <= push_data;
    end
  end

  // Registered read port; non-blocking read of r_mem gives read-first on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_data <= '0;
    end else if (w_pop_ok) begin
      r_pop_data <= r_mem[r_rd_ptr[ADDR_SIZE-1:0]];
    end
  end

  // Pointers wrap naturally modulo 2**(ADDR_SIZE+1); occupancy tracks accepted ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + L_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + L_ONE;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Rejected-operation pulses, visible the cycle after the offending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= push & w_full & ~w_pop_ok;
      r_underflow <= pop & w_empty;
    end
  end

  assign pop_data     = r_pop_data;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: doc/dyn_sync_fifo.md
# dyn_sync_fifo

Parametrised single-clock synchronous FIFO built on an inferred simple-dual-port RAM with a registered read port. It has an occupancy counter and run-time programmable almost-full/almost-empty thresholds. It is the buffering primitive for the dynamic-FIFO datapath and replaces direct instantiation of the bare dual-port RAM wherever ordered buffering with flow-control flags is needed. Depth and width are set at elaboration; thresholds may change every cycle.

## Interface
- DATA_SIZE, 32, width of each stored word in bits
- ADDR_SIZE, 4, RAM address width; DEPTH = 2**ADDR_SIZE entries (ADDR_SIZE ≥ 1)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- push  input  1  write request
- push_data  input  DATA_SIZE  word to enqueue, sampled with push
- pop  input  1  read request
- pop_data  output  DATA_SIZE  registered read data
- af_thresh  input  ADDR_SIZE+1  almost-full threshold
- ae_thresh  input  ADDR_SIZE+1  almost-empty threshold
- count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ af_thresh
- almost_empty  output  1  count ≤ ae_thresh
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

## Operation
- Storage: DEPTH × DATA_SIZE RAM. One write port and one registered read port. Read-first semantics apply when read and write addresses coincide in the same cycle.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide. The low ADDR_SIZE bits address the RAM.
  - Each pointer increments modulo 2**(ADDR_SIZE+1) on an accepted operation. Wrap is natural and needs no special case.
- Acceptance:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). A push while full is accepted if a pop is accepted in the same cycle.
- Accepted push: RAM[wr_ptr] ← push_data, then wr_ptr+1.
- Accepted pop: pop_data ← RAM[rd_ptr], then rd_ptr+1. pop_data holds its value until the next accepted pop.
- count update:
  - +1 on push_ok & !pop_ok
  - −1 on pop_ok & !push_ok
  - unchanged otherwise
- full, empty, almost_full and almost_empty are combinational compares of the registered count against constants or the live threshold inputs.
- Thresholds are unsigned. af_thresh = 0 forces almost_full = 1. ae_thresh ≥ DEPTH forces almost_empty = 1.
- overflow = push & full & !pop_ok, registered, so it pulses in the cycle after the rejected push.
- underflow = pop & empty, registered the same way.
- Rejected operations change no state other than the overflow/underflow pulse.
- Simultaneous push & pop when empty: the push is accepted, the pop is rejected and underflow pulses. The new word is not bypassed to pop_data.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, pop_data = 0, overflow = underflow = 0. almost_empty = 1 and almost_full = (af_thresh == 0). RAM contents are not reset.
- Reset mid-operation discards all contents. The cycle after rst deasserts starts empty, and a push in that cycle is accepted.
- Push-to-pop latency:
  - A word pushed in cycle N is visible through count/empty in N+1 and may be popped in N+1.
  - pop_data is valid in the cycle after the accepted pop.
- Flags and count change exactly one cycle after the accepted push/pop edge. There is no combinational path from push/pop to any output.
- Threshold inputs affect almost_full/almost_empty in the same cycle (combinational compare).
- Sustained simultaneous push & pop at any 0 < count ≤ DEPTH gives full throughput with count constant.

## Test plan
- Fill/drain (ADDR_SIZE=4, DATA_SIZE=32): reset, push 0x100..0x10F in 16 cycles -> full=1, count=16 after the last push. Then pop 16 times -> pop_data = 0x100..0x10F in order, each one cycle after its pop, then empty=1.
- Full + simultaneous push/pop: at count=16 drive push=1 (data 0xAAAA) and pop=1 -> pop_data = oldest word (read-first), count stays 16, overflow=0. 16 further pops end with 0xAAAA.
- Overflow/underflow:
  - push when full with pop=0 -> overflow pulses 1 cycle, count stays 16, contents unchanged.
  - pop when empty -> underflow pulses, pop_data holds its previous value.
- Dynamic thresholds: af_thresh=12, ae_thresh=3.
  - Push to count=12 -> almost_full rises that cycle.
  - Change af_thresh to 13 -> almost_full falls in the same cycle.
  - Drain to 3 -> almost_empty=1.
- Wrap-around: 40 random interleaved push/pop cycles keeping 0<count<16, pointers wrapping past 31 -> scoreboard matches every popped word, count tracks the model exactly.
- Reset mid-operation: at count=7 assert rst one cycle -> next cycle count=0, empty=1, pop_data=0. Push 0x55 then pop -> pop_data=0x55.
